// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shift stage op-select codes and sequencer state encodings.
package shift_sequencer_pkg;
  localparam logic [1:0] SHIFT_OP_ZERO = 2'b00;
  localparam logic [1:0] SHIFT_OP_PASS = 2'b01;
  localparam logic [1:0] SHIFT_OP_SHL  = 2'b10;
  localparam logic [1:0] SHIFT_OP_SHR  = 2'b11;
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_RUN  = 2'b01
  } seq_state_e;
endpackage

// File: rtl/shift_sequencer_shift.sv
// shift_sequencer_shift: single-bit shift stage (zero, pass, shift left, shift right) with carry out.
module shift_sequencer_shift
  import shift_sequencer_pkg::*;
#(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic [1:0] OP_SEL,
  input  logic [7:0] VALUE_IN,
  output logic [7:0] VALUE_OUT,
  output logic       CARRY_OUT
);
  // Delays only shape gate-level timing models; the RTL rejects nonsensical values.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("shift_sequencer_shift: negative delay");
  end
  always_comb begin
    VALUE_OUT = OP_SEL == SHIFT_OP_SHL  ? {VALUE_IN[6:0], 1'b0} :
                OP_SEL == SHIFT_OP_SHR  ? {1'b0, VALUE_IN[7:1]} :
                OP_SEL == SHIFT_OP_PASS ? VALUE_IN : 8'h00;
    CARRY_OUT = OP_SEL == SHIFT_OP_SHL ? VALUE_IN[7] :
                OP_SEL == SHIFT_OP_SHR ? VALUE_IN[0] : 1'b0;
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: latches an operand and applies 0-7 single-bit shifts/rotates, one per clock.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] VALUE_IN,
  input  logic [2:0] COUNT,
  input  logic       DIR,
  input  logic       ROT,
  output logic [7:0] RESULT,
  output logic       CARRY_OUT,
  output logic       ZERO_OUT,
  output logic       BUSY,
  output logic       DONE
);
  seq_state_e state_q;
  logic [7:0] result_q, sh_val, step_d;
  logic [2:0] remaining_q;
  logic       carry_q, zero_q, busy_q, done_q, dir_q, rot_q, sh_c;
  logic [1:0] sh_op;
  assign sh_op = state_q == SEQ_RUN ? (dir_q ? SHIFT_OP_SHR : SHIFT_OP_SHL) : SHIFT_OP_PASS;
  shift_sequencer_shift #(
    .DELAY_RISE(DELAY_RISE),
    .DELAY_FALL(DELAY_FALL)
  ) u_shift (
    .OP_SEL   (sh_op),
    .VALUE_IN (result_q),
    .VALUE_OUT(sh_val),
    .CARRY_OUT(sh_c)
  );
  // Rotate re-inserts the shifted-out bit at the vacated end.
  assign step_d = sh_val | {rot_q & dir_q & sh_c, 6'b0, rot_q & ~dir_q & sh_c};
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= SEQ_IDLE;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      rot_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SEQ_IDLE: if (START) begin
          result_q    <= VALUE_IN;
          carry_q     <= 1'b0;
          zero_q      <= VALUE_IN == 8'h00;
          remaining_q <= COUNT;
          dir_q       <= DIR;
          rot_q       <= ROT;
          done_q      <= COUNT == 3'd0;
          busy_q      <= COUNT != 3'd0;
          state_q     <= COUNT != 3'd0 ? SEQ_RUN : SEQ_IDLE;
        end
        SEQ_RUN: begin
          result_q    <= step_d;
          carry_q     <= sh_c;
          zero_q      <= step_d == 8'h00;
          remaining_q <= remaining_q - 3'd1;
          if (remaining_q == 3'd1) begin
            state_q <= SEQ_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end
  assign RESULT    = result_q;
  assign CARRY_OUT = carry_q;
  assign ZERO_OUT  = zero_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors with hand-computed results for shift_sequencer.
module tb_shift_sequencer;
  logic       CLK = 1'b0, RST = 1'b1, START = 1'b0, DIR = 1'b0, ROT = 1'b0;
  logic [7:0] VALUE_IN = 8'h00;
  logic [2:0] COUNT = 3'd0;
  logic [7:0] RESULT;
  logic       CARRY_OUT, ZERO_OUT, BUSY, DONE;
  int         n_chk = 0, n_pass = 0;
  shift_sequencer #(.DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .CLK(CLK), .RST(RST), .START(START), .VALUE_IN(VALUE_IN), .COUNT(COUNT),
    .DIR(DIR), .ROT(ROT), .RESULT(RESULT), .CARRY_OUT(CARRY_OUT),
    .ZERO_OUT(ZERO_OUT), .BUSY(BUSY), .DONE(DONE)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic start_op(input string tag, input logic [7:0] v, input logic [2:0] c, input logic d, input logic r);
    VALUE_IN = v; COUNT = c; DIR = d; ROT = r; START = 1'b1;
    tick();
    START = 1'b0;
    check({tag, "_load"}, RESULT, v);
    check({tag, "_carry0"}, CARRY_OUT, 0);
  endtask
  task automatic finish_op(input string tag, input int n, input logic [7:0] r, input logic c);
    int k = 0;
    while (!DONE && k < 20) begin
      check({tag, "_busy"}, BUSY, 1);
      k++;
      tick();
    end
    check({tag, "_steps"}, k, n);
    check({tag, "_result"}, RESULT, r);
    check({tag, "_carry"}, CARRY_OUT, c);
    check({tag, "_zero"}, ZERO_OUT, r == 8'h00);
    check({tag, "_idle"}, BUSY, 0);
    tick();
    check({tag, "_pulse"}, DONE, 0);
  endtask
  initial begin
    int seen;
    tick(); tick();
    check("rst_result", RESULT, 0);
    check("rst_flags", {CARRY_OUT, ZERO_OUT, BUSY, DONE}, 0);
    RST = 1'b0;
    tick();
    start_op("shl", 8'hB5, 3'd3, 1'b0, 1'b0);
    finish_op("shl", 3, 8'hA8, 1'b1);
    start_op("ror1", 8'h81, 3'd1, 1'b1, 1'b1);
    finish_op("ror1", 1, 8'hC0, 1'b1);
    start_op("ror7", 8'h81, 3'd7, 1'b1, 1'b1);
    finish_op("ror7", 7, 8'h03, 1'b0);
    start_op("zero", 8'h00, 3'd0, 1'b0, 1'b0);
    finish_op("zero", 0, 8'h00, 1'b0);
    start_op("rol", 8'h81, 3'd2, 1'b0, 1'b1);
    finish_op("rol", 2, 8'h06, 1'b0);
    // START during RUN must not disturb the op in flight
    start_op("ign", 8'hFF, 3'd5, 1'b1, 1'b0);
    tick();
    VALUE_IN = 8'h12; COUNT = 3'd0; DIR = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    check("ign_mid", RESULT, 8'h3F);
    finish_op("ign", 3, 8'h07, 1'b1);
    VALUE_IN = 8'h01; COUNT = 3'd2; DIR = 1'b0; ROT = 1'b0; START = 1'b1;
    tick();
    check("b2b_a_load", RESULT, 8'h01);
    VALUE_IN = 8'h80; COUNT = 3'd1; DIR = 1'b1; ROT = 1'b1;
    tick();
    check("b2b_a_step", RESULT, 8'h02);
    tick();
    check("b2b_a_done", {DONE, BUSY, RESULT}, {2'b10, 8'h04});
    tick();
    check("b2b_b_load", {DONE, BUSY, RESULT}, {2'b01, 8'h80});
    VALUE_IN = 8'h00; COUNT = 3'd0;
    tick();
    check("b2b_b_done", {DONE, BUSY, CARRY_OUT, RESULT}, {3'b100, 8'h40});
    tick();
    START = 1'b0;
    check("b2b_c_done", {DONE, BUSY, ZERO_OUT, RESULT}, {3'b101, 8'h00});
    tick();
    check("b2b_c_pulse", DONE, 0);
    start_op("rst", 8'hAA, 3'd5, 1'b0, 1'b0);
    tick(); tick();
    check("rst_mid_busy", {BUSY, RESULT}, {1'b1, 8'hA8});
    #2 RST = 1'b1;
    #1;
    check("rst_async_result", RESULT, 0);
    check("rst_async_flags", {CARRY_OUT, ZERO_OUT, BUSY, DONE}, 0);
    tick();
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      seen += int'(DONE) + int'(BUSY);
      tick();
    end
    check("rst_no_done", seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift/rotate sequencer that sits directly upstream of the single-bit `shift` stage. It drives that stage's operation select and input value, and consumes its value and carry outputs. It latches an 8-bit operand, then applies 0–7 single-bit left or right shifts, optionally as rotates, one per clock. It presents the final value with carry and zero flags to the register file / flags latch.

## Interface
Parameters:
- DELAY_RISE, default 0: rise delay; passed to the `shift` instance and applied to registered outputs.
- DELAY_FALL, default 0: fall delay; passed to the `shift` instance and applied to registered outputs.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  request a new operation; sampled only when BUSY=0.
- VALUE_IN  input  8  operand.
- COUNT  input  3  number of single-bit steps, 0–7.
- DIR  input  1  0 = left (towards bit 7), 1 = right.
- ROT  input  1  1 = rotate (the bit shifted out re-enters the vacated end); 0 = zero-fill.
- RESULT  output  8  current operand register.
- CARRY_OUT  output  1  last bit shifted out.
- ZERO_OUT  output  1  registered RESULT == 0.
- BUSY  output  1  high while steps remain.
- DONE  output  1  one-cycle pulse: result is final.

## Operation
- States: IDLE (BUSY=0), RUN (BUSY=1). 2-bit state register.
- IDLE & START at edge E0:
  - RESULT ← VALUE_IN; CARRY_OUT ← 0.
  - COUNT, DIR and ROT are latched into `remaining`, `dir_q` and `rot_q`.
  - COUNT=0: stay IDLE, DONE=1 for the next cycle.
  - COUNT≥1: go to RUN.
- Each RUN edge performs one step:
  - `shift` is driven with OP_SEL = dir_q ? 2'b11 : 2'b10 and VALUE_IN = RESULT.
  - RESULT ← VALUE_OUT, with the carry ORed into bit 0 (left) or bit 7 (right) when rot_q=1.
  - CARRY_OUT ← shift CARRY_OUT.
  - `remaining` decrements.
- On the RUN edge where `remaining` is 1: go to IDLE and set DONE for the next cycle.
- When not in RUN, OP_SEL = 2'b01 (pass), so the `shift` outputs mirror RESULT.
- ZERO_OUT is registered together with RESULT on every RESULT update.
- START while BUSY=1 is ignored; the latched operands are unaffected by input changes during RUN.
- START while DONE=1 is legal (the state is IDLE) and is accepted. Back-to-back ops therefore cost COUNT+1 cycles each (1 for COUNT=0).
- RESULT and the flags hold their values in IDLE until the next accepted START.
- RST asserted at any time, including mid-RUN: immediately state=IDLE and RESULT=0, CARRY_OUT=0, ZERO_OUT=0, BUSY=0, DONE=0, remaining=0. The aborted op produces no DONE.

## Timing
- All outputs are registered; reset values are all 0.
- Operation accepted at edge E0:
  - BUSY is high from E0 to E(N) for N≥1.
  - DONE is high for exactly the cycle following edge E(max(N,0)).
  - RESULT, CARRY_OUT and ZERO_OUT are final from the same edge.
- Intermediate RESULT values are visible during RUN and are not guaranteed meaningful to consumers.
- Combinational path per step: RESULT → `shift` (4+1 × 74153) → rotate OR → register. This path must meet one CLK period including DELAY_RISE/DELAY_FALL.

## Structure
- Shared `define header (shift_defs.vh), also used by the ALU decoder:
  - OP_SEL codes: SHIFT_OP_ZERO=2'b00, SHIFT_OP_PASS=2'b01, SHIFT_OP_SHL=2'b10, SHIFT_OP_SHR=2'b11.
  - Sequencer state encodings: SEQ_IDLE, SEQ_RUN.
- One sub-module: an instance of `shift` (parameters passed through).
- Everything else is local: counter, state, operand/flag registers and the rotate OR.

## Test plan
All tests run with delays = 0.
- Reset: assert RST mid-RUN of a COUNT=5 op → same cycle all outputs 0. After release, no DONE until a new START.
- Left shift: VALUE_IN=8'hB5, COUNT=3, DIR=0, ROT=0 → BUSY for 3 cycles, then DONE pulse with RESULT=8'hA8, CARRY_OUT=1, ZERO_OUT=0.
- Right rotate:
  - VALUE_IN=8'h81, COUNT=1, DIR=1, ROT=1 → RESULT=8'hC0, CARRY_OUT=1.
  - Same with COUNT=7 → RESULT=8'h03, CARRY_OUT=0.
- Zero count: VALUE_IN=8'h00, COUNT=0 → no BUSY, DONE the cycle after accept, RESULT=8'h00, CARRY_OUT=0, ZERO_OUT=1.
- Ignore while busy: VALUE_IN=8'hFF, COUNT=5, DIR=1, ROT=0, then START with 8'h12 two cycles later → that START is ignored; final RESULT=8'h07, CARRY_OUT=1.
- Back-to-back: hold START high with successive operands → each new op is accepted in the DONE cycle of the previous one, with no idle gap.
